sram_arbiter: RTL and testbench

// Shares the single external SRAM between the Z80 bus (decoded cpu_req) and the

---
 rtl/sram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// SRAM arbiter: shares one asynchronous SRAM between the Z80 bus and the video
// fetcher. Every access takes a fixed ACC_CYCLES clocks. Video has priority. A CPU
// request that loses a grant to video is served at the next decision point.
// cpu_wait stretches the CPU cycle until its access has been acknowledged.

module sram_arbiter #(
  parameter int unsigned ACC_CYCLES = 2,  // clocks per SRAM access, legal 2..8
  parameter int unsigned AW         = 19  // SRAM address width
) (
  input  logic          clk28,
  input  logic          rst_n,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  // Video side
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_data,
  output logic          vid_ack,
  // SRAM pins
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_do,
  output logic          ram_doe,
  input  logic [7:0]    ram_di,
  output logic          ram_oe_n,
  output logic          ram_we_n
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntLast = CntW'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StVid,
    StCpuRd,
    StCpuWr
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cpu_first_q, cpu_first_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic [7:0]      vid_data_q, vid_data_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            vid_ack_q, vid_ack_d;

  logic            last;
  logic            decide;
  logic            cpu_busy;
  logic            cpu_cand;
  logic            vid_cand;
  logic            grant_cpu;
  logic            grant_vid;

  // Arbitration: decisions happen when idle or in the final cycle of an access.
  always_comb begin
    cpu_busy = (state_q == StCpuRd) || (state_q == StCpuWr);
    last     = (state_q != StIdle) && (cnt_q == CntLast);
    decide   = (state_q == StIdle) || last;
    // A requester still holding req for the access in flight (final cycle) or just
    // acknowledged (ack cycle) must not be granted again on that stale request.
    cpu_cand  = cpu_req & ~cpu_ack_q & ~(last & cpu_busy);
    vid_cand  = vid_req & ~vid_ack_q & ~(last & (state_q == StVid));
    grant_cpu = decide & cpu_cand & (cpu_first_q | ~vid_cand);
    grant_vid = decide & vid_cand & ~grant_cpu;
  end

  // Next-state: access sequencing, data capture, ack generation and grants.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_first_d = cpu_first_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Read data is sampled at the end of the final cycle; ack follows one cycle later.
    if (last) begin
      unique case (state_q)
        StVid: begin
          vid_data_d = ram_di;
          vid_ack_d  = 1'b1;
        end
        StCpuRd: begin
          cpu_rdata_d = ram_di;
          cpu_ack_d   = 1'b1;
        end
        StCpuWr: begin
          cpu_ack_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (decide) begin
      cnt_d = '0;
      if (grant_cpu) begin
        state_d     = cpu_wr ? StCpuWr : StCpuRd;
        addr_d      = cpu_addr;
        cpu_first_d = 1'b0;
        if (cpu_wr) begin
          wdata_d = cpu_wdata;
        end
      end else if (grant_vid) begin
        state_d     = StVid;
        addr_d      = vid_addr;
        // A CPU passed over here goes first at the next decision.
        cpu_first_d = cpu_first_q | cpu_cand;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // Control state register; reset aborts any access without an ack.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cpu_first_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_first_q <= cpu_first_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  // Datapath registers: latched address/write data and returned read data.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

  // SRAM strobes decoded from state so an async reset releases them immediately.
  // WE is released in the final write cycle to give data hold time.
  always_comb begin
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_doe  = 1'b0;
    unique case (state_q)
      StVid, StCpuRd: begin
        ram_oe_n = 1'b0;
      end
      StCpuWr: begin
        ram_doe  = 1'b1;
        ram_we_n = (cnt_q == CntLast);
      end
      default: ;
    endcase
  end

  assign ram_a     = addr_q;
  assign ram_do    = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_data  = vid_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_wait  = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance a (ACC_CYCLES=2) and instance b (ACC_CYCLES=4),
// each on its own behavioural SRAM. Directed steps followed by randomized traffic
// checked against a memory scoreboard and the starvation bound.

module tb_sram_arbiter;

  localparam int AW = 19;

  logic clk = 1'b0;
  logic rst_n;

  logic          a_cpu_req, a_cpu_wr, a_cpu_ack, a_cpu_wait, a_vid_req, a_vid_ack;
  logic [AW-1:0] a_cpu_addr, a_vid_addr, a_ram_a;
  logic [7:0]    a_cpu_wdata, a_cpu_rdata, a_vid_data, a_ram_do, a_ram_di;
  logic          a_ram_doe, a_ram_oe_n, a_ram_we_n;

  logic          b_cpu_req, b_cpu_wr, b_cpu_ack, b_cpu_wait, b_vid_req, b_vid_ack;
  logic [AW-1:0] b_cpu_addr, b_vid_addr, b_ram_a;
  logic [7:0]    b_cpu_wdata, b_cpu_rdata, b_vid_data, b_ram_do, b_ram_di;
  logic          b_ram_doe, b_ram_oe_n, b_ram_we_n;

  logic [7:0] mem_a [0:(1<<AW)-1];
  logic [7:0] mem_b [0:(1<<AW)-1];
  logic [7:0] wmodel [int];

  int checks = 0;
  int errors = 0;
  int a_we_cnt = 0, a_doe_cnt = 0, b_we_cnt = 0, b_doe_cnt = 0;
  bit cpu_done;
  bit vid_cont;

  always #5 clk = ~clk;

  sram_arbiter #(.ACC_CYCLES(2), .AW(AW)) dut_a (
    .clk28(clk), .rst_n(rst_n),
    .cpu_req(a_cpu_req), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack), .cpu_wait(a_cpu_wait),
    .vid_req(a_vid_req), .vid_addr(a_vid_addr), .vid_data(a_vid_data), .vid_ack(a_vid_ack),
    .ram_a(a_ram_a), .ram_do(a_ram_do), .ram_doe(a_ram_doe), .ram_di(a_ram_di),
    .ram_oe_n(a_ram_oe_n), .ram_we_n(a_ram_we_n)
  );

  sram_arbiter #(.ACC_CYCLES(4), .AW(AW)) dut_b (
    .clk28(clk), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_wait(b_cpu_wait),
    .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_data(b_vid_data), .vid_ack(b_vid_ack),
    .ram_a(b_ram_a), .ram_do(b_ram_do), .ram_doe(b_ram_doe), .ram_di(b_ram_di),
    .ram_oe_n(b_ram_oe_n), .ram_we_n(b_ram_we_n)
  );

  // Asynchronous SRAM models.
  assign a_ram_di = mem_a[a_ram_a];
  assign b_ram_di = mem_b[b_ram_a];
  always @(posedge clk) begin
    if (!a_ram_we_n) mem_a[a_ram_a] = a_ram_do;
    if (!b_ram_we_n) mem_b[b_ram_a] = b_ram_do;
  end

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pin-level invariants and strobe-length counters, sampled mid-cycle.
  always @(negedge clk) begin
    check("a_doe_vs_oe", {31'b0, a_ram_doe & ~a_ram_oe_n}, 0);
    check("a_we_without_doe", {31'b0, ~a_ram_we_n & ~a_ram_doe}, 0);
    check("b_doe_vs_oe", {31'b0, b_ram_doe & ~b_ram_oe_n}, 0);
    check("b_we_without_doe", {31'b0, ~b_ram_we_n & ~b_ram_doe}, 0);
    if (!a_ram_we_n) a_we_cnt++;
    if (a_ram_doe) a_doe_cnt++;
    if (!b_ram_we_n) b_we_cnt++;
    if (b_ram_doe) b_doe_cnt++;
  end

  // One CPU access; req is held through the ack cycle and dropped the cycle after.
  // lat = clock edges from request to visible ack; vcnt = video acks seen meanwhile.
  task automatic cpu_op(input bit sel, input bit wr, input logic [AW-1:0] addr,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd,
                        output int vcnt);
    logic ack;
    if (sel) begin
      b_cpu_wr = wr; b_cpu_addr = addr; b_cpu_wdata = wd; b_cpu_req = 1'b1;
    end else begin
      a_cpu_wr = wr; a_cpu_addr = addr; a_cpu_wdata = wd; a_cpu_req = 1'b1;
    end
    lat = 0;
    vcnt = 0;
    ack = 1'b0;
    while (!ack && lat < 40) begin
      tick();
      lat++;
      ack = sel ? b_cpu_ack : a_cpu_ack;
      if (!sel && a_vid_ack) vcnt++;
    end
    check("cpu_ack_seen", {31'b0, ack}, 1);
    check("cpu_wait_in_ack", {31'b0, sel ? b_cpu_wait : a_cpu_wait}, 0);
    rd = sel ? b_cpu_rdata : a_cpu_rdata;
    tick();
    if (sel) b_cpu_req = 1'b0;
    else a_cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, vcnt, waitc, vack_at, cack_at, ack_cnt, ack_at;
    logic [7:0] rd;
    logic [AW-1:0] vaddr;

    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = pat(AW'(i));
      mem_b[i] = pat(AW'(i));
    end
    {a_cpu_req, a_cpu_wr, a_vid_req, b_cpu_req, b_cpu_wr, b_vid_req} = '0;
    a_cpu_addr = '0; a_vid_addr = '0; a_cpu_wdata = '0;
    b_cpu_addr = '0; b_vid_addr = '0; b_cpu_wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_oe_n", {31'b0, a_ram_oe_n}, 1);
    check("rst_we_n", {31'b0, a_ram_we_n}, 1);
    check("rst_doe", {31'b0, a_ram_doe}, 0);
    check("rst_ram_a", 32'(a_ram_a), 0);
    check("rst_ram_do", 32'(a_ram_do), 0);
    check("rst_acks", {30'b0, a_cpu_ack, a_vid_ack}, 0);
    check("rst_rdata", 32'(a_cpu_rdata), 0);
    check("rst_vdata", 32'(a_vid_data), 0);
    check("rst_b_strobes", {29'b0, b_ram_oe_n, b_ram_we_n, b_ram_doe}, 3'b110);

    // CPU write then read back, ACC_CYCLES=2.
    a_we_cnt = 0;
    cpu_op(0, 1, 19'h04000, 8'hA5, lat, rd, vcnt);
    check("wr_latency", 32'(lat), 3);
    check("wr_we_cycles", 32'(a_we_cnt), 1);
    repeat (3) begin
      tick();
      check("no_regrant", {29'b0, a_cpu_ack, a_ram_oe_n, a_ram_doe}, 3'b010);
    end
    a_we_cnt = 0;
    cpu_op(0, 0, 19'h04000, 8'h00, lat, rd, vcnt);
    check("rd_latency", 32'(lat), 3);
    check("rd_data", 32'(rd), 32'hA5);
    check("rd_we_cycles", 32'(a_we_cnt), 0);
    tick();

    // Simultaneous requests: video first, CPU back-to-back.
    vaddr = 19'h41234;
    a_vid_addr = vaddr; a_vid_req = 1'b1;
    a_cpu_wr = 1'b0; a_cpu_addr = 19'h04000; a_cpu_req = 1'b1;
    waitc = 0; vack_at = -1; cack_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (a_cpu_wait) waitc++;
      if (a_vid_ack) begin
        vack_at = i;
        check("sim_vid_data", 32'(a_vid_data), 32'(pat(vaddr)));
      end
      if (a_cpu_ack) begin
        cack_at = i;
        check("sim_cpu_data", 32'(a_cpu_rdata), 32'hA5);
      end
      if (vack_at >= 0 && i == vack_at + 1) a_vid_req = 1'b0;
      if (cack_at >= 0 && i == cack_at + 1) a_cpu_req = 1'b0;
      tick();
    end
    a_vid_req = 1'b0; a_cpu_req = 1'b0;
    check("sim_vid_ack_at", 32'(vack_at), 3);
    check("sim_cpu_ack_at", 32'(cack_at), 5);
    check("sim_wait_cycles", 32'(waitc), 5);

    // CPU drops req in the middle of a read.
    a_cpu_wr = 1'b0; a_cpu_addr = 19'h00300; a_cpu_req = 1'b1;
    ack_cnt = 0; ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) a_cpu_req = 1'b0;
      if (a_cpu_ack) begin
        ack_cnt++;
        ack_at = i;
        check("drop_rdata", 32'(a_cpu_rdata), 32'(pat(19'h00300)));
      end
      tick();
    end
    check("drop_ack_count", 32'(ack_cnt), 1);
    check("drop_ack_at", 32'(ack_at), 3);
    check("drop_idle", {30'b0, a_ram_oe_n, a_cpu_wait}, 2'b10);

    // Randomized traffic: continuous video first, then video with random gaps.
    for (int ph = 0; ph < 2; ph++) begin
      vid_cont = (ph == 0);
      cpu_done = 1'b0;
      fork
        begin : cpu_agent
          int l, vc;
          logic [7:0] r, d;
          logic [AW-1:0] ad;
          bit w;
          for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            w = 1'($urandom_range(0, 1));
            ad = 19'h00200 + AW'($urandom_range(0, 255));
            d = 8'($urandom);
            cpu_op(0, w, ad, d, l, r, vc);
            check("rnd_cpu_latency_bound", 32'(l <= 3 * 2 + 1), 1);
            check("rnd_vid_slots_before_cpu", 32'(vc <= 2), 1);
            if (w) wmodel[int'(ad)] = d;
            else check("rnd_cpu_rdata", 32'(r),
                       32'(wmodel.exists(int'(ad)) ? wmodel[int'(ad)] : pat(ad)));
          end
          cpu_done = 1'b1;
        end
        begin : vid_agent
          int n;
          logic [AW-1:0] va;
          while (!cpu_done) begin
            va = 19'h40000 + AW'($urandom_range(0, 19'h3FFFF));
            a_vid_addr = va;
            a_vid_req = 1'b1;
            n = 0;
            do begin
              tick();
              n++;
            end while (!a_vid_ack && n < 40);
            check("rnd_vid_ack_seen", {31'b0, a_vid_ack}, 1);
            check("rnd_vid_data", 32'(a_vid_data), 32'(pat(va)));
            tick();
            if (!vid_cont) begin
              a_vid_req = 1'b0;
              repeat ($urandom_range(0, 4)) tick();
            end
          end
          a_vid_req = 1'b0;
        end
      join
      repeat (4) tick();
    end

    // Reset in the middle of a CPU write.
    a_cpu_wr = 1'b1; a_cpu_addr = 19'h00100; a_cpu_wdata = 8'h77; a_cpu_req = 1'b1;
    tick();
    check("rstmid_we_active", {30'b0, a_ram_we_n, a_ram_doe}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_we_n", {31'b0, a_ram_we_n}, 1);
    check("rstmid_doe", {31'b0, a_ram_doe}, 0);
    check("rstmid_ram_a", 32'(a_ram_a), 0);
    tick();
    check("rstmid_no_ack", {31'b0, a_cpu_ack}, 0);
    tick();
    a_cpu_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      check("rstmid_no_ack_after", {31'b0, a_cpu_ack}, 0);
    end

    // ACC_CYCLES=4 instance.
    b_we_cnt = 0; b_doe_cnt = 0;
    cpu_op(1, 1, 19'h01234, 8'h3C, lat, rd, vcnt);
    check("b_wr_latency", 32'(lat), 5);
    check("b_we_cycles", 32'(b_we_cnt), 3);
    check("b_doe_cycles", 32'(b_doe_cnt), 4);
    cpu_op(1, 0, 19'h01234, 8'h00, lat, rd, vcnt);
    check("b_rd_latency", 32'(lat), 5);
    check("b_rd_data", 32'(rd), 32'h3C);
    b_vid_addr = 19'h55555; b_vid_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!b_vid_ack && lat < 40);
    check("b_vid_latency", 32'(lat), 5);
    check("b_vid_data", 32'(b_vid_data), 32'(pat(19'h55555)));
    tick();
    b_vid_req = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
